// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared widths and queue entry type for the register-file write-back controller
package regwb_pkg;

  localparam int REGWB_DATA_W = 64;
  localparam int REGWB_ADDR_W = 5;

  typedef struct packed {
    logic [REGWB_ADDR_W-1:0] addr;
    logic [REGWB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// rtl/regwb_fifo.sv - in-order write-back queue; storage and read pointer are exported for the head read and bypass search
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t [DEPTH-1:0]  entries,
  output logic [PTR_W-1:0]       rd_ptr,
  output logic [CNT_W-1:0]       count
);

  logic [PTR_W-1:0] wr_ptr;

  // Caller guarantees no push when full and no pop when empty; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset: only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - write-back controller for the 32x64 register file; optional queue bypass under REGWB_BYPASS_EN
module regfile_wb_ctrl
  import regwb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  pend_count,
  output logic              busy
`ifdef REGWB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data
`endif
);

  wb_entry_t [DEPTH-1:0] q_entries;
  wb_entry_t             in_entry;
  wb_entry_t             head;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  // Ready looks only at occupancy, so a full queue never passes through even on a pop.
  assign in_ready = (pend_count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = (pend_count != '0) && !wr_hold;
  assign in_entry = '{addr: in_addr, data: in_data};
  assign head     = q_entries[rd_ptr];
  assign busy     = (pend_count != '0) || wr_en;

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .entries    (q_entries),
    .rd_ptr     (rd_ptr),
    .count      (pend_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_addr <= head.addr;
      wr_data <= head.data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

`ifdef REGWB_BYPASS_EN
  // Scan oldest to newest so the youngest match wins; the in-flight write slot is older than all.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    if (wr_en && (wr_addr == q_addr)) begin
      q_hit  = 1'b1;
      q_data = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < pend_count) && (q_entries[rd_ptr + PTR_W'(i)].addr == q_addr)) begin
        q_hit  = 1'b1;
        q_data = q_entries[rd_ptr + PTR_W'(i)].data;
      end
    end
    if (q_addr == '0) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - randomized self-checking bench for regfile_wb_ctrl against a queue-based reference model
module tb_regfile_wb_ctrl;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              wr_hold = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  pend_count;
  logic              busy;
`ifdef REGWB_BYPASS_EN
  logic [ADDR_W-1:0] q_addr = '0;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .wr_hold    (wr_hold),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pend_count (pend_count),
    .busy       (busy)
`ifdef REGWB_BYPASS_EN
    ,
    .q_addr     (q_addr),
    .q_hit      (q_hit),
    .q_data     (q_data)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic [DATA_W-1:0] obs[$];
  logic              m_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                last_acc;
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    ent_t e;
    bit   acc;
    bit   pop;
`ifdef REGWB_BYPASS_EN
    bit                exp_hit;
    logic [DATA_W-1:0] exp_dat;
`endif
    @(negedge clk);
    check("wr_en", wr_en, m_en);
    if (m_en) begin
      check("wr_addr", wr_addr, m_addr);
      check("wr_data", wr_data, m_data);
      obs.push_back(wr_data);
    end
    check("pend_count", pend_count, mq.size());
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("busy", busy, (mq.size() != 0) || m_en);
`ifdef REGWB_BYPASS_EN
    exp_hit = 1'b0;
    exp_dat = '0;
    if (q_addr != 0) begin
      for (int i = mq.size() - 1; i >= 0 && !exp_hit; i--)
        if (mq[i].a == q_addr) begin exp_hit = 1'b1; exp_dat = mq[i].d; end
      if (!exp_hit && m_en && m_addr == q_addr) begin exp_hit = 1'b1; exp_dat = m_data; end
    end
    check("q_hit", q_hit, exp_hit);
    check("q_data", q_data, exp_dat);
`endif
    acc = in_valid && (mq.size() < DEPTH);
    pop = (mq.size() != 0) && !wr_hold;
    if (pop) begin
      e = mq.pop_front();
      m_en = 1'b1; m_addr = e.a; m_data = e.d;
    end else begin
      m_en = 1'b0;
    end
    if (acc && in_addr != 0) begin
      e.a = in_addr; e.d = in_data;
      mq.push_back(e);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int guard;
    model_reset();
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pend", pend_count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single write: pulse two edges after accept
    in_valid = 1'b1; in_addr = 3; in_data = 64'hDEAD_BEEF;
    cycle();
    in_valid = 1'b0;
    check("single_pend1", pend_count, 1);
    check("single_wen0", wr_en, 0);
    cycle();
    check("single_wen", wr_en, 1);
    check("single_addr", wr_addr, 3);
    check("single_data", wr_data, 64'hDEAD_BEEF);
    check("single_pend0", pend_count, 0);
    cycle();
    check("single_wen_end", wr_en, 0);

    // register 0 is absorbed
    in_valid = 1'b1; in_addr = 0; in_data = 64'hFFFF;
    check("r0_ready", in_ready, 1);
    cycle();
    in_valid = 1'b0;
    check("r0_acc", last_acc, 1);
    check("r0_pend", pend_count, 0);
    repeat (3) cycle();
    check("r0_wen", wr_en, 0);

    // full queue under hold, then release
    wr_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(i); in_data = 64'(i) << 8;
      cycle();
    end
    in_addr = 5; in_data = 64'h500;
    check("full_ready", in_ready, 0);
    check("full_pend", pend_count, 4);
    cycle();
    check("full_noacc", last_acc, 0);
    wr_hold = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      cycle();
      if (j == 1) check("full_5th_wait", last_acc, 0);
      if (j == 2) begin check("full_5th_acc", last_acc, 1); in_valid = 1'b0; end
      check("full_order_en", wr_en, 1);
      check("full_order", wr_addr, j);
    end
    repeat (2) cycle();

    // same-address stream across pointer wrap with random hold
    obs.delete();
    k = 1; guard = 0;
    while (k <= 12 && guard < 200) begin
      in_valid = 1'b1; in_addr = 7; in_data = 64'(k);
      wr_hold = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) k++;
      guard++;
    end
    check("stream_done", k, 13);
    in_valid = 1'b0; wr_hold = 1'b0;
    repeat (8) cycle();
    check("stream_count", obs.size(), 12);
    for (int i = 0; i < obs.size() && i < 12; i++) check("stream_order", obs[i], i + 1);

    // reset with work queued and a write in flight
    wr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = ADDR_W'(10 + i); in_data = 64'(100 + i);
      cycle();
    end
    in_valid = 1'b0; wr_hold = 1'b0;
    cycle();
    check("pre_rst_pend", pend_count, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", wr_en, 0);
    check("mid_rst_pend", pend_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_addr", wr_addr, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs.delete();
    repeat (5) cycle();
    check("post_rst_writes", obs.size(), 0);

`ifdef REGWB_BYPASS_EN
    wr_hold = 1'b1;
    in_valid = 1'b1; in_addr = 9; in_data = 64'hA;
    cycle();
    in_data = 64'hB;
    cycle();
    in_valid = 1'b0;
    q_addr = 9; #1;
    check("byp_hit", q_hit, 1);
    check("byp_data", q_data, 64'hB);
    q_addr = 0; #1;
    check("byp_zero", q_hit, 0);
    wr_hold = 1'b0;
    repeat (4) cycle();
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_addr  = ADDR_W'($urandom_range(0, 31));
      in_data  = {$urandom, $urandom};
      wr_hold  = 1'($urandom_range(0, 3) == 0);
`ifdef REGWB_BYPASS_EN
      q_addr   = ADDR_W'($urandom_range(0, 15));
`endif
      cycle();
    end
    in_valid = 1'b0; wr_hold = 1'b0;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller that feeds the write port of the 32×64-bit register file. It accepts register results from the execute stage over a valid/ready handshake and buffers them in a small in-order queue. It retires at most one entry per cycle onto the register file's `we`/`wa`/`wd` port. Writes to register 0 are absorbed and never reach the file.

## Interface

Parameters:
- `DATA_W`, 64: data width, matching register file word width.
- `ADDR_W`, 5: register address width (32 registers).
- `DEPTH`, 4: queue entries; must be a power of two, at least 2.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: a write-back result is offered.
- `in_ready`, output, 1: the controller can accept a result this cycle.
- `in_addr`, input, `ADDR_W`: destination register.
- `in_data`, input, `DATA_W`: result data.
- `wr_hold`, input, 1: the register file port is unavailable; no retire this cycle.
- `wr_en`, output, 1: write enable to the register file (registered).
- `wr_addr`, output, `ADDR_W`: write address (registered).
- `wr_data`, output, `DATA_W`: write data (registered).
- `pend_count`, output, `$clog2(DEPTH)+1`: number of occupied queue entries.
- `busy`, output, 1: high when `pend_count != 0` or `wr_en` is high.
- `q_addr`, input, `ADDR_W`: bypass lookup address. Present only with `REGWB_BYPASS_EN`.
- `q_hit`, output, 1: bypass hit. Present only with `REGWB_BYPASS_EN`.
- `q_data`, output, `DATA_W`: bypass data. Present only with `REGWB_BYPASS_EN`.

## Operation

- **Accept:** a transfer occurs on an edge where `in_valid && in_ready`.
- **Ready rule:** `in_ready = (pend_count < DEPTH)`. It does not depend on `in_valid`, and there is no pass-through when the queue is full, even if a pop happens in the same cycle.
- **Register 0:** a transfer with `in_addr == 0` is accepted and discarded. The queue is not pushed and `pend_count` is unchanged.
- **Retire:** on each edge where the queue is non-empty and `wr_hold == 0`:
  - pop the oldest entry;
  - register `wr_en=1`, `wr_addr`, `wr_data` from that entry.
- **Idle:** on any other edge, `wr_en` is registered to 0. `wr_addr` and `wr_data` hold their previous values.
- **Ordering:** strict FIFO order. Two writes to the same address retire in acceptance order, so the last accepted value wins in the file.
- **Simultaneous push and pop:** `pend_count` is unchanged. The pushed entry occupies the slot behind the popped one.
- **Wrap-around:** read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Full and empty are decided by `pend_count` only.

## Timing

- **Reset values** (asynchronous, effective while `rst_n == 0`):
  - `wr_en=0`, `wr_addr=0`, `wr_data=0`
  - `pend_count=0`, `busy=0`
  - `in_ready=1`
  - queue pointers 0
  - with the bypass compiled in: `q_hit=0` and `q_data=0`, as a consequence of the empty queue.
- **Reset mid-operation:** all queued and in-flight writes are lost. No `wr_en` pulse is produced after reset asserts.
- **Latency:** an entry accepted at edge k into an empty queue with `wr_hold=0`:
  - `wr_en` is high in the cycle following edge k+1;
  - the register file samples the write at edge k+2.
- **Throughput:** 1 write per cycle sustained when `wr_hold=0`.
- **`wr_hold`:** sampled per edge. Asserting it blocks only the next pop; an already-registered `wr_en` pulse still completes.

## Configuration

- **`REGWB_BYPASS_EN` defined:**
  - `q_addr`, `q_hit` and `q_data` exist.
  - The lookup is combinational over the queue entries plus the registered `wr_*` slot when `wr_en=1`. It picks the newest matching entry, with the `wr_*` slot being the oldest.
  - `q_addr == 0` never hits.
  - On a miss, `q_data = 0`.
- **`REGWB_BYPASS_EN` not defined:** the three ports and the lookup logic are absent. Readers must stall while `busy`.

## Structure

- **Package `regwb_pkg`:**
  - constants `REGWB_DATA_W=64` and `REGWB_ADDR_W=5`;
  - `typedef struct packed { logic [REGWB_ADDR_W-1:0] addr; logic [REGWB_DATA_W-1:0] data; } wb_entry_t`.
- **Sub-module `regwb_fifo`:**
  - parameterised `DEPTH` queue of `wb_entry_t`;
  - push and pop with a count output;
  - exposes the entry array and read pointer for the bypass search.
- **Top-level `regfile_wb_ctrl`:** holds the register-0 filter, the registered write port and the bypass.

## Test plan

- **Single write:** after reset, push (addr=3, data=0xDEAD_BEEF) → `wr_en=1`, `wr_addr=3`, `wr_data=0xDEADBEEF` exactly 2 cycles after the accept edge, for one cycle. `pend_count` goes 0→1→0.
- **Register 0 filter:** push (addr=0, data=0xFFFF) → accepted with `in_ready=1`, `pend_count` stays 0, and `wr_en` never rises.
- **Full queue:** hold `wr_hold=1` and push 5 entries to addr 1–5 → first 4 accepted, `in_ready=0` with `pend_count=4`. Release `wr_hold` → 4 consecutive writes in order 1,2,3,4. The 5th entry is accepted when `pend_count` drops to 3.
- **Same-address ordering and wrap-around:** stream 12 pushes to addr 7 with data 1..12 and toggle `wr_hold` randomly → writes appear in order 1..12, with no loss or duplication across pointer wrap.
- **Reset mid-operation:** with 3 entries queued, assert `rst_n=0` for 1 cycle → all outputs are at reset values immediately, and no writes follow.
- **Bypass (`REGWB_BYPASS_EN`):** queue addr 9 with data 0xA, then addr 9 with data 0xB, while `wr_hold=1`; set `q_addr=9` → `q_hit=1`, `q_data=0xB`. Set `q_addr=0` → `q_hit=0`.
